// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: the data width and the FSM state encoding.
package mem_stage_pkg;

   localparam int DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE       = 2'b00,
      ACCESS     = 2'b01,
      ERRO_ABORT = 2'b10
   } state_t;

endpackage

// File: rtl/mem_stage_timeout_ctr.sv
// Counts consecutive ACCESS cycles without mem_ready; hit fires on the last allowed cycle.
module mem_timeout_ctr #(
   parameter int LIMIT = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic hit
);

   localparam int CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign hit = enable && (cnt_q == CW'(LIMIT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clear || hit)
         cnt_d = '0;
      else if (enable)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: passes ALU results through, or runs one load/store on the memory bus.
// Define MEM_STAGE_TIMEOUT_EN to abort accesses that wait TIMEOUT_CICLOS cycles for mem_ready.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int TIMEOUT_CICLOS = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] endereco,
   input  logic [DATA_W-1:0] dado_escrita,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic              valid_in,
   output logic              stall,
   output logic [DATA_W-1:0] resultado,
   output logic              valid_out,
   output logic              erro,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   state_t            state_q;
   logic [DATA_W-1:0] resultado_q;
   logic              valid_out_q;
   logic              erro_q;
   logic              mem_req_q;
   logic              mem_we_q;
   logic [DATA_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic              is_mem;
   logic              hit;

   assign is_mem = mem_read | mem_write;

`ifdef MEM_STAGE_TIMEOUT_EN
   logic ctr_en;
   logic ctr_clr;

   assign ctr_en  = (state_q == ACCESS) && !mem_ready;
   assign ctr_clr = (state_q != ACCESS) || mem_ready;

   mem_timeout_ctr #(
      .LIMIT (TIMEOUT_CICLOS)
   ) u_timeout_ctr (
      .clock  (clock),
      .reset  (reset),
      .clear  (ctr_clr),
      .enable (ctr_en),
      .hit    (hit)
   );
`else
   assign hit = 1'b0;
`endif

   // The abort cycle holds back a waiting instruction so it is not dropped.
   always_comb begin
      stall = 1'b0;
      case (state_q)
         IDLE:       stall = valid_in && is_mem;
         ACCESS:     stall = !mem_ready && !hit;
         ERRO_ABORT: stall = valid_in;
         default:    stall = 1'b0;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         resultado_q <= '0;
         valid_out_q <= 1'b0;
         erro_q      <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         valid_out_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (valid_in) begin
                  if (is_mem) begin
                     mem_req_q   <= 1'b1;
                     mem_we_q    <= mem_write;
                     mem_addr_q  <= endereco;
                     mem_wdata_q <= dado_escrita;
                     state_q     <= ACCESS;
                  end else begin
                     resultado_q <= endereco;
                     valid_out_q <= 1'b1;
                  end
               end
            end
            ACCESS: begin
               if (mem_ready) begin
                  mem_req_q   <= 1'b0;
                  valid_out_q <= 1'b1;
                  resultado_q <= mem_we_q ? mem_addr_q : mem_rdata;
                  state_q     <= IDLE;
               end else if (hit) begin
                  mem_req_q   <= 1'b0;
                  erro_q      <= 1'b1;
                  valid_out_q <= 1'b1;
                  resultado_q <= '0;
                  state_q     <= ERRO_ABORT;
               end
            end
            ERRO_ABORT: state_q <= IDLE;
            default:    state_q <= IDLE;
         endcase
      end
   end

   assign resultado = resultado_q;
   assign valid_out = valid_out_q;
   assign erro      = erro_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: pass-through, load with waits, stores, timeout abort, reset mid-access.
module tb_mem_stage;

   logic        clock = 1'b0;
   logic        reset;
   logic [15:0] endereco;
   logic [15:0] dado_escrita;
   logic        mem_read;
   logic        mem_write;
   logic        valid_in;
   logic        stall;
   logic [15:0] resultado;
   logic        valid_out;
   logic        erro;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_ready;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clock = ~clock;

   mem_stage #(.TIMEOUT_CICLOS(16)) dut (
      .clock        (clock),
      .reset        (reset),
      .endereco     (endereco),
      .dado_escrita (dado_escrita),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .valid_in     (valid_in),
      .stall        (stall),
      .resultado    (resultado),
      .valid_out    (valid_out),
      .erro         (erro),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_ready    (mem_ready)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   initial begin
      logic all_stall;
      reset = 1'b1; valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      endereco = '0; dado_escrita = '0; mem_rdata = '0; mem_ready = 1'b0;
      #3;
      chk("rst_mem_req",   {15'd0, mem_req},   16'd0);
      chk("rst_mem_we",    {15'd0, mem_we},    16'd0);
      chk("rst_mem_addr",  mem_addr,           16'd0);
      chk("rst_mem_wdata", mem_wdata,          16'd0);
      chk("rst_resultado", resultado,          16'd0);
      chk("rst_valid_out", {15'd0, valid_out}, 16'd0);
      chk("rst_erro",      {15'd0, erro},      16'd0);
      chk("rst_stall",     {15'd0, stall},     16'd0);
      tick; tick; reset = 1'b0;

      // non-memory pass-through
      tick; valid_in = 1'b1; endereco = 16'h00A5; #1;
      chk("nm_stall", {15'd0, stall}, 16'd0);
      tick; valid_in = 1'b0; #1;
      chk("nm_vout", {15'd0, valid_out}, 16'd1);
      chk("nm_res",  resultado,          16'h00A5);
      chk("nm_stall2", {15'd0, stall},   16'd0);
      tick;
      chk("nm_vout_clr", {15'd0, valid_out}, 16'd0);

      // load, three wait cycles
      valid_in = 1'b1; mem_read = 1'b1; endereco = 16'h0010; mem_ready = 1'b0; #1;
      chk("ld_stall_issue", {15'd0, stall}, 16'd1);
      for (int k = 1; k <= 3; k++) begin
         tick; valid_in = 1'b0; mem_read = 1'b0; endereco = 16'hFFFF; #1;
         chk("ld_stall_wait", {15'd0, stall},     16'd1);
         chk("ld_addr_hold",  mem_addr,           16'h0010);
         chk("ld_req",        {15'd0, mem_req},   16'd1);
         chk("ld_we",         {15'd0, mem_we},    16'd0);
         chk("ld_vout_wait",  {15'd0, valid_out}, 16'd0);
      end
      tick; mem_ready = 1'b1; mem_rdata = 16'hBEEF; #1;
      chk("ld_stall_ready", {15'd0, stall}, 16'd0);
      chk("ld_addr_ready",  mem_addr,       16'h0010);
      tick; mem_ready = 1'b0; #1;
      chk("ld_vout", {15'd0, valid_out}, 16'd1);
      chk("ld_res",  resultado,          16'hBEEF);
      chk("ld_req_drop", {15'd0, mem_req}, 16'd0);

      // zero-wait store; mem_ready already high in the issue cycle
      valid_in = 1'b1; mem_write = 1'b1; endereco = 16'h0020; dado_escrita = 16'h1234; mem_ready = 1'b1; #1;
      chk("st_stall_issue", {15'd0, stall}, 16'd1);
      tick; valid_in = 1'b0; mem_write = 1'b0; #1;
      chk("st_req",   {15'd0, mem_req},   16'd1);
      chk("st_we",    {15'd0, mem_we},    16'd1);
      chk("st_wdata", mem_wdata,          16'h1234);
      chk("st_stall_acc", {15'd0, stall}, 16'd0);
      chk("st_vout_acc", {15'd0, valid_out}, 16'd0);
      tick; mem_ready = 1'b0; #1;
      chk("st_vout", {15'd0, valid_out}, 16'd1);
      chk("st_res",  resultado,          16'h0020);
      chk("st_req_drop", {15'd0, mem_req}, 16'd0);

      // read and write together behave as a store
      valid_in = 1'b1; mem_read = 1'b1; mem_write = 1'b1; endereco = 16'h0030; dado_escrita = 16'h5555; #1;
      chk("rw_stall_issue", {15'd0, stall}, 16'd1);
      tick; valid_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_ready = 1'b1; mem_rdata = 16'hDEAD; #1;
      chk("rw_we",    {15'd0, mem_we}, 16'd1);
      chk("rw_wdata", mem_wdata,       16'h5555);
      tick; mem_ready = 1'b0; #1;
      chk("rw_vout", {15'd0, valid_out}, 16'd1);
      chk("rw_res",  resultado,          16'h0030);
      chk("rw_erro", {15'd0, erro},      16'd0);

      // load that never sees mem_ready
      valid_in = 1'b1; mem_read = 1'b1; endereco = 16'h0040; #1;
`ifdef MEM_STAGE_TIMEOUT_EN
      for (int k = 1; k <= 16; k++) begin
         tick; valid_in = 1'b0; mem_read = 1'b0; #1;
         chk("to_stall", {15'd0, stall}, (k < 16) ? 16'd1 : 16'd0);
         chk("to_vout_wait", {15'd0, valid_out}, 16'd0);
      end
      tick; #1;
      chk("to_vout",  {15'd0, valid_out}, 16'd1);
      chk("to_erro",  {15'd0, erro},      16'd1);
      chk("to_res",   resultado,          16'h0000);
      chk("to_req",   {15'd0, mem_req},   16'd0);
      chk("to_stall_abort", {15'd0, stall}, 16'd0);
      tick;
      chk("to_vout_clr", {15'd0, valid_out}, 16'd0);
      chk("to_erro_hold", {15'd0, erro},     16'd1);
      valid_in = 1'b1; mem_read = 1'b1; endereco = 16'h0050; #1;
      tick; valid_in = 1'b0; mem_read = 1'b0; mem_ready = 1'b1; mem_rdata = 16'h7777; #1;
      tick; mem_ready = 1'b0; #1;
      chk("after_to_vout", {15'd0, valid_out}, 16'd1);
      chk("after_to_res",  resultado,          16'h7777);
      chk("after_to_erro", {15'd0, erro},      16'd1);
`else
      all_stall = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         tick; valid_in = 1'b0; mem_read = 1'b0; #1;
         all_stall = all_stall & stall & ~valid_out;
      end
      chk("nto_wait", {15'd0, all_stall}, 16'd1);
      chk("nto_erro", {15'd0, erro},      16'd0);
      mem_ready = 1'b1; mem_rdata = 16'h4444;
      tick; mem_ready = 1'b0; #1;
      chk("nto_vout", {15'd0, valid_out}, 16'd1);
      chk("nto_res",  resultado,          16'h4444);
`endif

      // reset in the third ACCESS cycle
      tick; valid_in = 1'b1; mem_read = 1'b1; endereco = 16'h0060; #1;
      tick; valid_in = 1'b0; mem_read = 1'b0;
      tick; tick; #1;
      chk("mr_req_before", {15'd0, mem_req}, 16'd1);
      reset = 1'b1; #1;
      chk("mr_req_async", {15'd0, mem_req}, 16'd0);
      chk("mr_addr",      mem_addr,         16'h0000);
      chk("mr_erro",      {15'd0, erro},    16'd0);
      #1 reset = 1'b0;
      tick;
      chk("mr_no_vout", {15'd0, valid_out}, 16'd0);
      chk("mr_req_off", {15'd0, mem_req},   16'd0);
      valid_in = 1'b1; endereco = 16'h00C3; #1;
      chk("mr_idle_stall", {15'd0, stall}, 16'd0);
      tick; valid_in = 1'b0; #1;
      chk("mr_next_vout", {15'd0, valid_out}, 16'd1);
      chk("mr_next_res",  resultado,          16'h00C3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
